tt_um_pa1mantri_cdc_fifo: RTL and testbench
===========================================

Name: tt_um_pa1mantri_cdc_fifo

Overview:
- TinyTapeout user tile implementing an 8-deep x 8-bit FIFO with CDC-style architecture: Gray-coded write/read pointers, each crossing to the opposite side through a 2-flop synchronizer.
- Both sides run on the single tile clock; the synchronizer latency gives conservative, glitch-free full/empty flags.
- Data enters on ui_in and leaves on uo_out; control and status use the uio bus.

Parameters:
- DEPTH_LOG2, 3, address width; FIFO depth = 8 entries.
- DATA_W, 8, data width; fixed by the pin budget.
- SYNC_STAGES, 2, synchronizer flops per pointer crossing.

Ports:
- clk  input  1  tile clock; all flops on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  tile enable; when 0, writes and reads are ignored and all state holds.
- ui_in  input  8  write data.
- uio_in  input  8  [0]=wr_en, [1]=rd_en, [7:2] unused.
- uo_out  output  8  registered read data.
- uio_out  output  8  [0]=0, [1]=0, [2]=full, [3]=empty, [4]=overflow, [5]=underflow, [7:6]=see Optional Feature.
- uio_oe  output  8  constant 8'b1111_1100.

Behaviour:
- Reset (async, rst_n=0): both pointers, all synchronizer flops, uo_out, overflow and underflow = 0; empty=1, full=0. Memory contents are not reset.
- Pointers are 4-bit binary plus a Gray copy (ptr ^ ptr>>1); the memory address is binary[2:0].
- Write side: wq1 <= wgray, wq2 <= wq1 (write pointer into read side). Read side: rq1 <= rgray, rq2 <= rq1.
- full (combinational) = wgray == {~rq2[3:2], rq2[1:0]}.
- empty (combinational) = rgray == wq2.
- Write: at a rising edge with ena & wr_en & !full, mem[waddr] <= ui_in and the write pointer increments.
- Write attempted while full: no store, pointer holds, overflow <= 1 (sticky until reset).
- Read: at a rising edge with ena & rd_en & !empty, uo_out <= mem[raddr] and the read pointer increments. Data appears on uo_out the cycle after the read edge.
- Read attempted while empty: uo_out holds, pointer holds, underflow <= 1 (sticky until reset).
- Latency: a write at edge k deasserts empty after edge k+2. A read at edge k deasserts full after edge k+2. Own-side flags update immediately (empty after a read, full after a write).
- Simultaneous wr_en and rd_en: both are evaluated independently against their own flags in the same cycle.
- Wrap-around: 4-bit pointers wrap naturally; the MSB distinguishes full from empty.
- Reset mid-operation: the FIFO empties at once and flags return to reset values.
- Writes are blocked only by full (conservative, based on the stale read pointer), so no data corruption occurs.

Optional Feature:
- Macro FIFO_ALMOST_FLAGS_EN.
- When defined: uio_out[6] = almost_full, asserted when write-side count (wbin - bin(rq2)) >= 7. uio_out[7] = almost_empty, asserted when read-side count (bin(wq2) - rbin) <= 1. Gray-to-binary conversion is done locally on each side.
- When undefined: uio_out[7:6] = 0 and no conversion logic is built.

Test Plan:
- Reset check: hold rst_n=0 -> uo_out=0x00, uio_out[3]=1, uio_out[2,4,5]=0, uio_oe=0xFC.
- Write 0xA5 at edge 1 -> empty stays 1 through edge 2 and is 0 after edge 3. Read at edge 4 -> uo_out=0xA5 and empty=1 after edge 4.
- Write 0x01..0x08 back-to-back -> full=1 after the 8th write. A 9th write of 0xFF -> overflow=1 and the FIFO is unchanged. Read 8 times -> 0x01..0x08 in order.
- Read while empty after reset -> underflow=1, uo_out stays 0x00.
- Write and read every cycle (after pre-filling 2 entries) for 20 cycles with incrementing data -> output in order, no flag errors, pointers wrap cleanly.
- ena=0 with wr_en=rd_en=1 for 5 cycles -> no pointer or flag change. With FIFO_ALMOST_FLAGS_EN defined, 7 writes -> uio_out[6]=1; drain to 1 entry -> uio_out[7]=1.

Source files
------------

// File: rtl/tt_um_pa1mantri_cdc_fifo.sv
// rtl/tt_um_pa1mantri_cdc_fifo.sv - 8x8 FIFO with Gray pointers crossing through synchronizers.
// Optional almost-full/almost-empty flags on uio_out[7:6] via FIFO_ALMOST_FLAGS_EN.
module tt_um_pa1mantri_cdc_fifo #(
  parameter int DEPTH_LOG2  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DATA_W = 8;
  localparam int PW     = DEPTH_LOG2 + 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  logic [PW-1:0]     wbin_q, wbin_d, rbin_q, rbin_d;
  logic [PW-1:0]     wgray, rgray, wq2, rq2;
  logic [PW-1:0]     wsync_q [SYNC_STAGES];
  logic [PW-1:0]     wsync_d [SYNC_STAGES];
  logic [PW-1:0]     rsync_q [SYNC_STAGES];
  logic [PW-1:0]     rsync_d [SYNC_STAGES];
  logic [DATA_W-1:0] mem_q   [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_req, rd_req, wr_fire, rd_fire;
  logic              full, empty, almost_full, almost_empty;
  logic              unused_ok;

  assign wgray = wbin_q ^ (wbin_q >> 1);
  assign rgray = rbin_q ^ (rbin_q >> 1);
  assign wq2   = wsync_q[SYNC_STAGES-1];
  assign rq2   = rsync_q[SYNC_STAGES-1];

  // Full when the write pointer is a whole lap ahead of the (stale) read pointer.
  assign full    = wgray == {~rq2[PW-1:PW-2], rq2[PW-3:0]};
  assign empty   = rgray == wq2;

  assign wr_req  = ena & uio_in[0];
  assign rd_req  = ena & uio_in[1];
  assign wr_fire = wr_req & ~full;
  assign rd_fire = rd_req & ~empty;

  always_comb begin
    wbin_d = wbin_q;
    rbin_d = rbin_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    for (int i = 0; i < SYNC_STAGES; i++) begin
      wsync_d[i] = wsync_q[i];
      rsync_d[i] = rsync_q[i];
    end
    if (wr_fire) wbin_d = wbin_q + 1'b1;
    if (wr_req && full) ovf_d = 1'b1;
    if (rd_fire) begin
      rbin_d = rbin_q + 1'b1;
      dout_d = mem_q[rbin_q[DEPTH_LOG2-1:0]];
    end
    if (rd_req && empty) udf_d = 1'b1;
    if (ena) begin
      wsync_d[0] = wgray;
      rsync_d[0] = rgray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wsync_d[i] = wsync_q[i-1];
        rsync_d[i] = rsync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      rbin_q  <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      wsync_q <= '{default: '0};
      rsync_q <= '{default: '0};
    end else begin
      wbin_q  <= wbin_d;
      rbin_q  <= rbin_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      wsync_q <= wsync_d;
      rsync_q <= rsync_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wbin_q[DEPTH_LOG2-1:0]] <= ui_in;
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] wcount, rcount;
  assign wcount       = wbin_q - gray2bin(rq2);
  assign rcount       = gray2bin(wq2) - rbin_q;
  assign almost_full  = wcount >= PW'(DEPTH - 1);
  assign almost_empty = rcount <= PW'(1);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

  assign uo_out    = dout_q;
  assign uio_out   = {almost_empty, almost_full, udf_q, ovf_q, empty, full, 2'b00};
  assign uio_oe    = 8'b1111_1100;
  assign unused_ok = &{1'b0, uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_pa1mantri_cdc_fifo.sv
// tb/tb_tt_um_pa1mantri_cdc_fifo.sv - self-checking bench for the tile FIFO.
module tb_tt_um_pa1mantri_cdc_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int errors = 0;
  int checks = 0;

  tt_um_pa1mantri_cdc_fifo dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Reference: data queue plus total write/read counts, each side seeing the
  // other's count as it stood two enabled edges earlier.
  logic [7:0] mq[$];
  int m_wr, m_rd, m_wmid, m_wseen, m_rmid, m_rseen;
  logic [7:0] m_dout;
  bit m_ovf, m_udf;

  task automatic model_reset();
    mq.delete();
    m_wr = 0; m_rd = 0; m_wmid = 0; m_wseen = 0; m_rmid = 0; m_rseen = 0;
    m_dout = 8'h00; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_edge(input bit e, input bit w, input bit r, input logic [7:0] d);
    bit full_pre, empty_pre;
    int old_wr, old_rd;
    if (!e) return;
    full_pre  = (m_wr - m_rseen) == 8;
    empty_pre = (m_rd == m_wseen);
    old_wr = m_wr;
    old_rd = m_rd;
    if (w) begin
      if (full_pre) m_ovf = 1;
      else begin mq.push_back(d); m_wr++; end
    end
    if (r) begin
      if (empty_pre) m_udf = 1;
      else begin m_dout = mq.pop_front(); m_rd++; end
    end
    m_wseen = m_wmid; m_wmid = old_wr;
    m_rseen = m_rmid; m_rmid = old_rd;
  endtask

  function automatic logic [7:0] exp_uio();
    bit f, e, af, ae;
    f  = (m_wr - m_rseen) == 8;
    e  = (m_rd == m_wseen);
    af = 0; ae = 0;
`ifdef FIFO_ALMOST_FLAGS_EN
    af = (m_wr - m_rseen) >= 7;
    ae = (m_wseen - m_rd) <= 1;
`endif
    return {ae, af, m_udf, m_ovf, e, f, 2'b00};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_uo_out"}, uo_out, m_dout);
    chk({tag, "_uio_out"}, uio_out, exp_uio());
    chk({tag, "_uio_oe"}, uio_oe, 8'hFC);
  endtask

  task automatic step(input bit e, input bit w, input bit r, input logic [7:0] d);
    logic [5:0] junk;
    junk = 6'($urandom);
    ena = e; ui_in = d; uio_in = {junk, r, w};
    @(posedge clk);
    model_edge(e, w, r, d);
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b0; uio_in = 8'h00; ui_in = 8'h00;
    #2;
    model_reset();
    check_all("reset");
    chk("reset_empty", uio_out[3], 1);
    chk("reset_uo", uo_out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit e; bit w; bit r;
    logic [7:0] d;
    logic [7:0] exp_uo;
    logic [3:0] exp_flags;  // {underflow, overflow, empty, full}
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 0, 1, 8'h00, 8'h00, 4'b1010};
    tbl[1]  = '{1, 1, 0, 8'hA5, 8'h00, 4'b1010};
    tbl[2]  = '{1, 0, 0, 8'h00, 8'h00, 4'b1010};
    tbl[3]  = '{1, 0, 0, 8'h00, 8'h00, 4'b1000};
    tbl[4]  = '{1, 0, 1, 8'h00, 8'hA5, 4'b1010};
    tbl[5]  = '{0, 1, 1, 8'h55, 8'hA5, 4'b1010};
    tbl[6]  = '{0, 1, 1, 8'h55, 8'hA5, 4'b1010};
    tbl[7]  = '{1, 1, 0, 8'h3C, 8'hA5, 4'b1010};
    tbl[8]  = '{1, 1, 1, 8'hC3, 8'hA5, 4'b1010};
    tbl[9]  = '{1, 0, 0, 8'h00, 8'hA5, 4'b1000};
    tbl[10] = '{1, 0, 1, 8'h00, 8'h3C, 4'b1000};
    tbl[11] = '{1, 0, 1, 8'h00, 8'hC3, 4'b1010};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].e, tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d_uo", i), uo_out, tbl[i].exp_uo);
      chk($sformatf("tbl%0d_flags", i), uio_out[5:2], tbl[i].exp_flags);
    end

    // Fill to full, overflow, then drain in order.
    do_reset();
    for (int k = 1; k <= 8; k++) step(1, 1, 0, 8'(k));
    chk("full_after_8", uio_out[2], 1);
    step(1, 1, 0, 8'hFF);
    chk("overflow_set", uio_out[4], 1);
    chk("full_hold", uio_out[2], 1);
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 1, 8'h00);
      chk($sformatf("drain_%0d", k), uo_out, k);
    end
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("drained_empty", uio_out[3], 1);
    chk("drained_no_udf", uio_out[5], 0);

    // Streaming with simultaneous read/write after a 2-entry prefill.
    do_reset();
    step(1, 1, 0, 8'h80);
    step(1, 1, 0, 8'h81);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 8'(8'h82 + i));

    // Tile disabled: nothing moves.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 8'(i));

`ifdef FIFO_ALMOST_FLAGS_EN
    do_reset();
    for (int k = 0; k < 7; k++) step(1, 1, 0, 8'(k));
    chk("almost_full", uio_out[6], 1);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int k = 0; k < 6; k++) step(1, 0, 1, 8'h00);
    chk("almost_empty", uio_out[7], 1);
`endif

    // Random traffic with phases biased towards full and towards empty.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 150) % 2) ? 80 : 25;
      if ($urandom_range(0, 249) == 0) do_reset();
      else step($urandom_range(0, 99) < 90, $urandom_range(0, 99) < wp,
                $urandom_range(0, 99) < 50, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
